// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the mode-0 SPI slave.
// SPI_SLAVE_OVERRUN_EN (defined by the build) enables rx_ack/rx_overrun.
package spi_pkg;

    typedef enum logic [0:0] {
        IDLE,
        SHIFT
    } spi_slv_state_e;

    localparam int         SPI_DATA_WIDTH    = 8;
    localparam logic [7:0] SPI_UNDERRUN_BYTE = 8'h00;

endpackage

// File: rtl/spi_slave_if.sv
// SCLK/MOSI/SS_n/MISO link between an SPI master and this slave.
// Signal names follow the pin names on the link.
interface spi_slave_if;

    logic SCLK;
    logic MOSI;
    logic SS_n;
    logic MISO;

    modport master (
        output SCLK,
        output MOSI,
        output SS_n,
        input  MISO
    );

    modport slave (
        input  SCLK,
        input  MOSI,
        input  SS_n,
        output MISO
    );

endinterface

// File: rtl/spi_slave_sync_edge.sv
// N-stage synchronizer with registered one-cycle rise/fall pulses.
// RST_VAL sets the idle level the chain holds during reset.
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
            prev_q <= sync_q[STAGES-1];
            rise   <= sync_q[STAGES-1] & ~prev_q;
            fall   <= ~sync_q[STAGES-1] & prev_q;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// Mode-0 MSB-first SPI slave, oversampled in the clk domain.
// Optional SPI_SLAVE_OVERRUN_EN: level rx_valid with rx_ack and sticky rx_overrun.
module spi_slave
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH  = SPI_DATA_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    spi_slave_if.slave            spi,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_load,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid
`ifdef SPI_SLAVE_OVERRUN_EN
    ,
    input  logic                  rx_ack,
    output logic                  rx_overrun
`endif
);

    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic ss_lvl, ss_rise, ss_fall;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic mosi_bit;
    logic unused_edges;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
        .clk   (clk),
        .reset (reset),
        .d     (spi.SCLK),
        .q     (sclk_lvl),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss (
        .clk   (clk),
        .reset (reset),
        .d     (spi.SS_n),
        .q     (ss_lvl),
        .rise  (ss_rise),
        .fall  (ss_fall)
    );

    assign unused_edges = ^{sclk_lvl, ss_rise, ss_fall};

    always_ff @(posedge clk) begin
        if (reset) mosi_sync <= '0;
        else       mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi.MOSI};
    end

    assign mosi_bit = mosi_sync[SYNC_STAGES-1];

    spi_slv_state_e        state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_WIDTH-1:0] tx_buf_q, tx_buf_d;
    logic                  tx_ready_q, tx_ready_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  done, load_pt;
`ifdef SPI_SLAVE_OVERRUN_EN
    logic                  ovr_q, ovr_d;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rx_shift_q <= '0;
            tx_shift_q <= '0;
            tx_buf_q   <= '0;
            tx_ready_q <= 1'b1;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
`ifdef SPI_SLAVE_OVERRUN_EN
            ovr_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rx_shift_q <= rx_shift_d;
            tx_shift_q <= tx_shift_d;
            tx_buf_q   <= tx_buf_d;
            tx_ready_q <= tx_ready_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
`ifdef SPI_SLAVE_OVERRUN_EN
            ovr_q      <= ovr_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rx_shift_d = rx_shift_q;
        tx_shift_d = tx_shift_q;
        tx_buf_d   = tx_buf_q;
        tx_ready_d = tx_ready_q;
        rx_data_d  = rx_data_q;
        done       = 1'b0;
        load_pt    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!ss_lvl) begin
                    load_pt = 1'b1;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // Deselect has priority over any SCLK edge in the same cycle.
                if (ss_lvl) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (sclk_rise) begin
                    rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], mosi_bit};
                    if (cnt_q == LAST) begin
                        cnt_d     = '0;
                        done      = 1'b1;
                        rx_data_d = {rx_shift_q[DATA_WIDTH-2:0], mosi_bit};
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else if (sclk_fall) begin
                    if (cnt_q != '0) tx_shift_d = tx_shift_q << 1;
                    else             load_pt    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A load in the same cycle lands in tx_buf after the shift reg takes the old one.
        if (load_pt) begin
            tx_shift_d = tx_ready_q ? DATA_WIDTH'(SPI_UNDERRUN_BYTE) : tx_buf_q;
            tx_ready_d = 1'b1;
        end
        if (tx_load && tx_ready_q) begin
            tx_buf_d   = tx_data;
            tx_ready_d = 1'b0;
        end

`ifdef SPI_SLAVE_OVERRUN_EN
        rx_valid_d = done | (rx_valid_q & ~rx_ack);
        ovr_d      = ovr_q;
        if (done && rx_valid_q)  ovr_d = 1'b1;
        else if (rx_ack && !done) ovr_d = 1'b0;
`else
        rx_valid_d = done;
`endif
    end

    assign spi.MISO = tx_shift_q[DATA_WIDTH-1];
    assign tx_ready = tx_ready_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
`ifdef SPI_SLAVE_OVERRUN_EN
    assign rx_overrun = ovr_q;
`endif

endmodule
